// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The stall counter is sized from MEM_LAT through stall_cnt_w().
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hazard_state_e;

  localparam int REG_ZERO = 0;

  function automatic int stall_cnt_w(input int mem_lat);
    return $clog2(mem_lat) + 1;
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear.
// Used for the hazard controller's performance statistics.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: multi-cycle load-use stalls, branch flush, data-memory wait freeze.
// Performance counters are built only when HAZ_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Ex_memRead,
  input  logic              Ex_jump_or_branch,
  input  logic [REG_AW-1:0] Ex_RegRd,
  input  logic [REG_AW-1:0] ID_RegRs1,
  input  logic [REG_AW-1:0] ID_RegRs2,
  input  logic              ID_useRs1,
  input  logic              ID_useRs2,
  input  logic              dmem_wait,
  output logic              IF_ID_flush,
  output logic              ID_Ex_flush,
  output logic              IF_ID_freeze,
  output logic              pc_freeze,
  output logic              Ex_Mem_freeze,
  output logic              stall_busy,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  localparam int CW = stall_cnt_w(MEM_LAT);

  hazard_state_e state_q, state_d;
  hazard_state_e saved_q, saved_d;
  hazard_state_e eff_state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit;
  logic          stall_inc;
  logic          flush_inc;

  assign hit = Ex_memRead && (Ex_RegRd != REG_AW'(REG_ZERO)) &&
               ((ID_useRs1 && (ID_RegRs1 == Ex_RegRd)) ||
                (ID_useRs2 && (ID_RegRs2 == Ex_RegRd)));

  // While parked in MEM_WAIT, the cycle the wait drops behaves as the saved state.
  assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    cnt_d         = cnt_q;
    IF_ID_flush   = 1'b0;
    ID_Ex_flush   = 1'b0;
    IF_ID_freeze  = 1'b0;
    pc_freeze     = 1'b0;
    Ex_Mem_freeze = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (rst_n) begin
      if (dmem_wait) begin
        pc_freeze     = 1'b1;
        IF_ID_freeze  = 1'b1;
        Ex_Mem_freeze = 1'b1;
        state_d       = MEM_WAIT;
        if (state_q != MEM_WAIT) begin
          saved_d = state_q;
        end
      end else if (Ex_jump_or_branch) begin
        IF_ID_flush = 1'b1;
        ID_Ex_flush = 1'b1;
        flush_inc   = 1'b1;
        state_d     = IDLE;
        saved_d     = IDLE;
        cnt_d       = '0;
      end else if (eff_state == LOAD_STALL) begin
        ID_Ex_flush  = 1'b1;
        pc_freeze    = 1'b1;
        IF_ID_freeze = 1'b1;
        stall_inc    = 1'b1;
        saved_d      = IDLE;
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = LOAD_STALL;
          cnt_d   = cnt_q - CW'(1);
        end
      end else if (hit) begin
        ID_Ex_flush  = 1'b1;
        pc_freeze    = 1'b1;
        IF_ID_freeze = 1'b1;
        stall_inc    = 1'b1;
        saved_d      = IDLE;
        if (MEM_LAT == 1) begin
          state_d = IDLE;
        end else begin
          state_d = LOAD_STALL;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end else begin
        state_d = IDLE;
        saved_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      saved_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_busy = (state_q != IDLE);

`ifdef HAZ_PERF_CNT_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (perf_stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (1'b0),
    .count (perf_flush_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf    = stall_inc ^ flush_inc;
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (MEM_LAT=1 and MEM_LAT=3) driven by the same directed stimulus,
// expected output vectors queued at drive time and popped when sampled.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       Ex_memRead;
  logic       Ex_jump_or_branch;
  logic [4:0] Ex_RegRd;
  logic [4:0] ID_RegRs1;
  logic [4:0] ID_RegRs2;
  logic       ID_useRs1;
  logic       ID_useRs2;
  logic       dmem_wait;

  logic        if_id_flush1, id_ex_flush1, if_id_freeze1, pc_freeze1, ex_mem_freeze1, busy1;
  logic        if_id_flush3, id_ex_flush3, if_id_freeze3, pc_freeze3, ex_mem_freeze3, busy3;
  logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
  logic [5:0]  obs1, obs3;

  int checks   = 0;
  int failures = 0;

  // Output vector order: {IF_ID_flush, ID_Ex_flush, IF_ID_freeze, pc_freeze, Ex_Mem_freeze, stall_busy}
  localparam logic [5:0] NONE   = 6'b000000;
  localparam logic [5:0] BUSY   = 6'b000001;
  localparam logic [5:0] STALL  = 6'b011100;
  localparam logic [5:0] STALLB = 6'b011101;
  localparam logic [5:0] FLUSH  = 6'b110000;
  localparam logic [5:0] FLUSHB = 6'b110001;
  localparam logic [5:0] WAITF  = 6'b001110;
  localparam logic [5:0] WAITB  = 6'b001111;

  typedef struct {
    logic [5:0] e1;
    logic [5:0] e3;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(1), .CNT_W(32)) u_lat1 (
    .clk               (clk),
    .rst_n             (rst_n),
    .Ex_memRead        (Ex_memRead),
    .Ex_jump_or_branch (Ex_jump_or_branch),
    .Ex_RegRd          (Ex_RegRd),
    .ID_RegRs1         (ID_RegRs1),
    .ID_RegRs2         (ID_RegRs2),
    .ID_useRs1         (ID_useRs1),
    .ID_useRs2         (ID_useRs2),
    .dmem_wait         (dmem_wait),
    .IF_ID_flush       (if_id_flush1),
    .ID_Ex_flush       (id_ex_flush1),
    .IF_ID_freeze      (if_id_freeze1),
    .pc_freeze         (pc_freeze1),
    .Ex_Mem_freeze     (ex_mem_freeze1),
    .stall_busy        (busy1),
    .perf_stall_cnt    (stall_cnt1),
    .perf_flush_cnt    (flush_cnt1)
  );

  hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(32)) u_lat3 (
    .clk               (clk),
    .rst_n             (rst_n),
    .Ex_memRead        (Ex_memRead),
    .Ex_jump_or_branch (Ex_jump_or_branch),
    .Ex_RegRd          (Ex_RegRd),
    .ID_RegRs1         (ID_RegRs1),
    .ID_RegRs2         (ID_RegRs2),
    .ID_useRs1         (ID_useRs1),
    .ID_useRs2         (ID_useRs2),
    .dmem_wait         (dmem_wait),
    .IF_ID_flush       (if_id_flush3),
    .ID_Ex_flush       (id_ex_flush3),
    .IF_ID_freeze      (if_id_freeze3),
    .pc_freeze         (pc_freeze3),
    .Ex_Mem_freeze     (ex_mem_freeze3),
    .stall_busy        (busy3),
    .perf_stall_cnt    (stall_cnt3),
    .perf_flush_cnt    (flush_cnt3)
  );

  assign obs1 = {if_id_flush1, id_ex_flush1, if_id_freeze1, pc_freeze1, ex_mem_freeze1, busy1};
  assign obs3 = {if_id_flush3, id_ex_flush3, if_id_freeze3, pc_freeze3, ex_mem_freeze3, busy3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic mr, input logic jb, input logic dw,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic us1, input logic us2,
                               input logic [5:0] e1, input logic [5:0] e3);
    exp_t e;
    Ex_memRead        = mr;
    Ex_jump_or_branch = jb;
    dmem_wait         = dw;
    Ex_RegRd          = rd;
    ID_RegRs1         = rs1;
    ID_RegRs2         = rs2;
    ID_useRs1         = us1;
    ID_useRs2         = us2;
    e.e1  = e1;
    e.e3  = e3;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      checkVal({e.tag, "_lat1"}, 32'(obs1), 32'(e.e1));
      checkVal({e.tag, "_lat3"}, 32'(obs3), 32'(e.e3));
    end
  endtask

  task automatic step(input string tag, input logic mr, input logic jb, input logic dw,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic us1, input logic us2,
                      input logic [5:0] e1, input logic [5:0] e3);
    @(posedge clk);
    #1;
    applyStimulus(tag, mr, jb, dw, rd, rs1, rs2, us1, us2, e1, e3);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input string tag, input logic [5:0] e1, input logic [5:0] e3);
    step(tag, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, e1, e3);
  endtask

  task automatic checkPerf(input string tag, input int s1, input int s3, input int f1, input int f3);
`ifdef HAZ_PERF_CNT_EN
    checkVal({tag, "_stall1"}, stall_cnt1, 32'(s1));
    checkVal({tag, "_stall3"}, stall_cnt3, 32'(s3));
    checkVal({tag, "_flush1"}, flush_cnt1, 32'(f1));
    checkVal({tag, "_flush3"}, flush_cnt3, 32'(f3));
`else
    checkVal({tag, "_stall1"}, stall_cnt1, 32'(s1 * 0));
    checkVal({tag, "_stall3"}, stall_cnt3, 32'(s3 * 0));
    checkVal({tag, "_flush1"}, flush_cnt1, 32'(f1 * 0));
    checkVal({tag, "_flush3"}, flush_cnt3, 32'(f3 * 0));
`endif
  endtask

  initial begin
    // Reset held with every hazard input active: outputs must stay low.
    rst_n             = 1'b0;
    Ex_memRead        = 1'b1;
    Ex_jump_or_branch = 1'b1;
    dmem_wait         = 1'b1;
    Ex_RegRd          = 5'd5;
    ID_RegRs1         = 5'd5;
    ID_RegRs2         = 5'd5;
    ID_useRs1         = 1'b1;
    ID_useRs2         = 1'b1;
    #2;
    checkVal("reset_out_lat1", 32'(obs1), 32'(NONE));
    checkVal("reset_out_lat3", 32'(obs3), 32'(NONE));
    checkPerf("reset", 0, 0, 0, 0);
    @(negedge clk);
    Ex_memRead        = 1'b0;
    Ex_jump_or_branch = 1'b0;
    dmem_wait         = 1'b0;
    rst_n             = 1'b1;

    // Single load-use hit: 1 bubble at MEM_LAT=1, 3 bubbles at MEM_LAT=3.
    step("t1_hit", 1, 0, 0, 5'd5, 5'd5, 5'd0, 1, 0, STALL, STALL);
    idle("t1_c2", NONE, STALLB);
    idle("t1_c3", NONE, STALLB);
    idle("t1_c4", NONE, NONE);
    checkPerf("t1", 1, 3, 0, 0);

    // No-hit cases, then Rs1==Rs2==Rd giving one stall sequence.
    step("t3_rd0",    1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, NONE, NONE);
    step("t3_nouse",  1, 0, 0, 5'd7, 5'd3, 5'd7, 1, 0, NONE, NONE);
    step("t3_noload", 0, 0, 0, 5'd7, 5'd7, 5'd7, 1, 1, NONE, NONE);
    step("t3_dbl",    1, 0, 0, 5'd9, 5'd9, 5'd9, 1, 1, STALL, STALL);
    idle("t3_dbl_c2", NONE, STALLB);
    idle("t3_dbl_c3", NONE, STALLB);
    idle("t3_dbl_c4", NONE, NONE);
    checkPerf("t3", 2, 6, 0, 0);

    // Branch in the second stall cycle aborts the stall.
    step("t4_hit", 1, 0, 0, 5'd6, 5'd1, 5'd6, 0, 1, STALL, STALL);
    step("t4_br",  0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, FLUSH, FLUSHB);
    idle("t4_after", NONE, NONE);
    checkPerf("t4", 3, 7, 1, 1);

    // Memory wait during a load stall: branch ignored while waiting, stall resumes with same count.
    step("t5_hit", 1, 0, 0, 5'd5, 5'd5, 5'd0, 1, 0, STALL, STALL);
    step("t5_w1",  0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, WAITF, WAITB);
    step("t5_w2",  0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, WAITB, WAITB);
    step("t5_w3",  0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0, WAITB, WAITB);
    step("t5_w4",  0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, WAITB, WAITB);
    idle("t5_res1", BUSY, STALLB);
    idle("t5_res2", NONE, STALLB);
    idle("t5_done", NONE, NONE);
    checkPerf("t5", 4, 10, 1, 1);

    // Asynchronous reset in the middle of a wait.
    step("t6_hit", 1, 0, 0, 5'd5, 5'd5, 5'd0, 1, 0, STALL, STALL);
    step("t6_w1",  0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, WAITF, WAITB);
    step("t6_w2",  1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, WAITB, WAITB);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("t6_rst_lat1", 32'(obs1), 32'(NONE));
    checkVal("t6_rst_lat3", 32'(obs3), 32'(NONE));
    checkPerf("t6_rst", 0, 0, 0, 0);
    @(negedge clk);
    Ex_memRead = 1'b0;
    dmem_wait  = 1'b0;
    ID_useRs1  = 1'b0;
    rst_n      = 1'b1;
    idle("t6_post_idle", NONE, NONE);
    step("t6_post_hit", 1, 0, 0, 5'd4, 5'd4, 5'd0, 1, 0, STALL, STALL);
    idle("t6_post_c2", NONE, STALLB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
